stream_demux: RTL
=================

Name: stream_demux

Overview:
- Registered 1-to-LANE_NUM demultiplexer; the distributing counterpart to the N-to-1 word selectors in the redundancy datapath.
- Accepts one word per cycle over a valid/ready handshake and routes it to the output lane chosen by in_sel.
- Each lane has a one-entry holding register with its own valid/ready handshake, so a stalled lane blocks only words addressed to it.
- Out-of-range selects are dropped and counted. A synchronous flush clears all lanes.

Parameters:
- WORD_WIDTH, 8, width of one data word.
- LANE_NUM, 8, number of output lanes; range 2..64.
- SEL_WIDTH, 3, width of in_sel; must equal ceil(log2(LANE_NUM)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all lane registers.
- in_valid  input  1  in_word/in_sel are valid.
- in_ready  output  1  block can accept the presented word this cycle.
- in_word  input  WORD_WIDTH  data word.
- in_sel  input  SEL_WIDTH  destination lane index.
- out_valid  output  LANE_NUM  bit k: lane k holds a word.
- out_ready  input  LANE_NUM  bit k: consumer of lane k takes the word this cycle.
- out_word  output  LANE_NUM*WORD_WIDTH  lane k word at bits [k*WORD_WIDTH +: WORD_WIDTH].
- drop_cnt  output  8  count of words dropped for out-of-range select; saturates at 255.

Behaviour:
Reset:
- While reset_n=0, independent of clk: out_valid=0, out_word=0, drop_cnt=0.
- Release takes effect at the next rising edge.

Definitions:
- in_range = (in_sel < LANE_NUM).
- pop[k] = out_valid[k] & out_ready[k].
- accept = in_valid & in_ready.

in_ready (combinational):
- 0 while flush=1.
- Otherwise 1 when in_range=0.
- Otherwise equals !out_valid[in_sel] | out_ready[in_sel].
- May depend combinationally on in_sel and out_ready; the upstream must not make in_valid depend on in_ready.

Lane k, each edge, in priority order:
- flush=1: out_valid[k] <= 0; out_word unchanged; no accept.
- accept & in_range & in_sel==k: out_word[k] <= in_word; out_valid[k] <= 1. This also covers a pop and push on the same lane in one cycle: the lane stays valid and holds the new word, with no bubble.
- pop[k]: out_valid[k] <= 0; out_word[k] retains its value.
- Otherwise: hold.

Stability and timing:
- Latency: a word accepted at edge N is visible on its lane after edge N, one cycle.
- While out_valid[k]=1 and out_ready[k]=0, out_word[k] is stable.
- Words to different lanes never block each other; at most one lane loads per cycle.
- Per-lane order is preserved. Order across lanes is not defined.

Drop counter:
- accept & !in_range: word discarded, drop_cnt <= drop_cnt+1, saturating at 255.
- Not cleared by flush; only reset_n clears it.

Other rules:
- out_ready[k] while out_valid[k]=0 has no effect.
- in_sel and in_word are ignored when in_valid=0.
- Reset asserted mid-transfer: all held words are lost, no partial state survives, and in_ready is valid again on the first cycle after release.
- With LANE_NUM = 2^SEL_WIDTH the drop path is unreachable; drop_cnt stays 0.

Test Plan:
- Reset, then in_sel=3, in_word=0xA5, in_valid for 1 cycle, out_ready=0 -> next cycle out_valid=0x08, lane3 word=0xA5; stays held for 5 stalled cycles.
- Lane 3 full and stalled, present in_sel=3 -> in_ready=0. Then present in_sel=5, in_word=0x3C -> accepted, out_valid=0x28.
- Lane 2 full, in the same cycle out_ready[2]=1 and push in_sel=2, in_word=0x77 -> lane2 stays valid with 0x77, no bubble. A further push of 0x78 to lane 2 with out_ready[2]=0 -> in_ready=0.
- LANE_NUM=6, SEL_WIDTH=3, push in_sel=7 three times -> in_ready=1, no out_valid change, drop_cnt=3. 260 pushes -> drop_cnt=255.
- Lanes 0,1,4 valid, assert flush with in_valid=1 -> in_ready=0, next cycle out_valid=0, drop_cnt unchanged.
- Assert reset_n=0 asynchronously mid-stream with lanes valid -> out_valid, out_word and drop_cnt are 0 before the next edge.

Source files
------------

// File: rtl/stream_demux.sv
// Registered 1-to-LANE_NUM demux: one word per cycle is routed to lane in_sel and lands in that lane's holding register one cycle later.
// Backpressure is per lane: in_ready drops only when the addressed lane is full and not draining; out-of-range selects are always accepted, then counted and dropped.
module stream_demux #(
  parameter int WORD_WIDTH = 8,
  parameter int LANE_NUM   = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORD_WIDTH-1:0]          in_word,
  input  logic [SEL_WIDTH-1:0]           in_sel,
  output logic [LANE_NUM-1:0]            out_valid,
  input  logic [LANE_NUM-1:0]            out_ready,
  output logic [LANE_NUM*WORD_WIDTH-1:0] out_word,
  output logic [7:0]                     drop_cnt
);

  localparam logic [SEL_WIDTH:0] LANE_LIM = (SEL_WIDTH+1)'(LANE_NUM);

  logic [WORD_WIDTH-1:0] r_word [LANE_NUM];
  logic [LANE_NUM-1:0]   r_valid;
  logic [7:0]            r_drop;

  logic [LANE_NUM-1:0]   w_sel_hit;
  logic [LANE_NUM-1:0]   w_pop;
  logic [LANE_NUM-1:0]   w_load;
  logic                  w_in_range;
  logic                  w_busy;
  logic                  w_accept;

  // One-hot of the addressed lane; all-zero when in_sel is out of range.
  always_comb begin
    w_sel_hit = '0;
    for (int k = 0; k < LANE_NUM; k++) begin
      w_sel_hit[k] = (in_sel == SEL_WIDTH'(k));
    end
  end

  assign w_in_range = ({1'b0, in_sel} < LANE_LIM);
  assign w_busy     = |(w_sel_hit & r_valid & ~out_ready);
  assign in_ready   = !flush && !w_busy;
  assign w_accept   = in_valid && in_ready;
  assign w_pop      = r_valid & out_ready;
  assign w_load     = {LANE_NUM{w_accept}} & w_sel_hit;

  // Load wins over pop so a same-cycle drain and refill leaves no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int k = 0; k < LANE_NUM; k++) begin
        r_word[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LANE_NUM; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_load[k]) begin
          r_word[k]  <= in_word;
          r_valid[k] <= 1'b1;
        end else if (w_pop[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= '0;
    end else if (w_accept && !w_in_range && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  generate
    for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane_out
      assign out_word[g*WORD_WIDTH +: WORD_WIDTH] = r_word[g];
    end
  endgenerate

  assign out_valid = r_valid;
  assign drop_cnt  = r_drop;

endmodule
